// File: rtl/soma_scan_ctrl_if.sv
// Soma update bus and spike stream between the scan controller and its neighbours.
// The master side is the scan controller. It drives the soma/sd issue signals
// and presents the spike FIFO head. The slave side supplies the fire result
// and the consumer's ready.
interface soma_scan_ctrl_if #(
    parameter int NNW = 12
) ();
    logic           soma_vld;
    logic [NNW-1:0] soma_vm_addr;
    logic           soma_clear;
    logic           sd_re;
    logic [NNW-1:0] sd_raddr;
    logic           soma_fire;
    logic           spk_valid;
    logic           spk_ready;
    logic [NNW-1:0] spk_addr;

    modport master (
        output soma_vld, soma_vm_addr, soma_clear, sd_re, sd_raddr,
        output spk_valid, spk_addr,
        input  soma_fire, spk_ready
    );

    modport slave (
        input  soma_vld, soma_vm_addr, soma_clear, sd_re, sd_raddr,
        input  spk_valid, spk_addr,
        output soma_fire, spk_ready
    );
endinterface

// File: rtl/soma_scan_ctrl.sv
// Per-timestep soma sequencer.
// It sweeps a contiguous neuron range and issues one soma/sd access per cycle.
// It samples the soma fire flag one cycle after each issue and queues the
// indices of firing neurons in a show-ahead spike FIFO for the axon encoder.
// A clear sweep walks the same range with soma_clear set and queues nothing.
// An issue is allowed only while the FIFO keeps two free slots: one for the
// sample already in flight and one for the access being issued. Because of
// this the FIFO cannot overflow and no fire is ever lost.
module soma_scan_ctrl #(
    parameter int NNW = 12,
    parameter int FD  = 4
) (
    input  logic            clk_soma,
    input  logic            rst_n,
    input  logic            step_start,
    input  logic            clear_start,
    input  logic [NNW-1:0]  nrn_base,
    input  logic [NNW-1:0]  nrn_num,
    soma_scan_ctrl_if.master bus,
    output logic            busy,
    output logic            done
);

    localparam int DEPTH = 1 << FD;
    localparam logic [FD:0] DEPTH_C  = {1'b1, {FD{1'b0}}};
    localparam logic [FD:0] DEPTH_M2 = {1'b0, {(FD-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t         state;
    logic           mode_clear;
    logic [NNW-1:0] base_q;
    logic [NNW-1:0] num_q;
    logic [NNW-1:0] idx;

    // Issue stage: registered outputs that go to soma and sd.
    logic           vld_p0;
    logic [NNW-1:0] addr_p0;
    logic           clear_p0;

    // Fire-sample stage: the issue from the previous cycle, lined up with soma_fire.
    logic           vld_p1;
    logic [NNW-1:0] addr_p1;
    logic           clear_p1;

    // Spike FIFO
    logic [NNW-1:0] mem [DEPTH];
    logic [FD-1:0]  wr_ptr;
    logic [FD-1:0]  rd_ptr;
    logic [FD:0]    count;
    logic [FD:0]    count_next;
    logic           push;
    logic           pop;
    logic           spk_valid_int;
    logic           can_issue;

    assign spk_valid_int = (count != '0);

    // FIFO handshake and occupancy that the next issue cycle will see.
    always_comb begin
        push       = vld_p1 && !clear_p1 && bus.soma_fire && (count != DEPTH_C);
        pop        = spk_valid_int && bus.spk_ready;
        count_next = count + {{FD{1'b0}}, push} - {{FD{1'b0}}, pop};
        can_issue  = (count_next <= DEPTH_M2);
    end

    // Sweep sequencer. Issue outputs are decided one cycle ahead, so they leave registered.
    always_ff @(posedge clk_soma or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mode_clear <= 1'b0;
            base_q     <= '0;
            num_q      <= '0;
            idx        <= '0;
            vld_p0     <= 1'b0;
            addr_p0    <= '0;
            clear_p0   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            vld_p0   <= 1'b0;
            clear_p0 <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    // clear_start wins when both pulses coincide
                    if (clear_start || step_start) begin
                        base_q     <= nrn_base;
                        num_q      <= nrn_num;
                        mode_clear <= clear_start;
                        busy       <= 1'b1;
                        if (nrn_num == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            idx   <= '0;
                        end else begin
                            state <= SCAN;
                            if (can_issue) begin
                                vld_p0   <= 1'b1;
                                addr_p0  <= nrn_base;
                                clear_p0 <= clear_start;
                                idx      <= NNW'(1);
                            end else begin
                                idx <= '0;
                            end
                        end
                    end
                end
                SCAN: begin
                    if (idx == num_q) begin
                        state <= DRAIN;
                    end else if (can_issue) begin
                        vld_p0   <= 1'b1;
                        addr_p0  <= base_q + idx;
                        clear_p0 <= mode_clear;
                        idx      <= idx + NNW'(1);
                    end
                end
                DRAIN: begin
                    state <= FINISH;
                    done  <= 1'b1;
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Fire-sample stage control: remember whether last cycle issued, and in which mode.
    always_ff @(posedge clk_soma or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            clear_p1 <= 1'b0;
        end else begin
            vld_p1   <= vld_p0;
            clear_p1 <= clear_p0;
        end
    end

    // Fire-sample stage data: the neuron index issued in the previous cycle.
    always_ff @(posedge clk_soma) begin
        addr_p1 <= addr_p0;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_soma or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FD'(1);
            if (pop)  rd_ptr <= rd_ptr + FD'(1);
            count <= count_next;
        end
    end

    // FIFO storage: write the firing neuron index on push.
    always_ff @(posedge clk_soma) begin
        if (push) mem[wr_ptr] <= addr_p1;
    end

    assign bus.soma_vld     = vld_p0;
    assign bus.soma_vm_addr = addr_p0;
    assign bus.soma_clear   = clear_p0;
    assign bus.sd_re        = vld_p0;
    assign bus.sd_raddr     = addr_p0;
    assign bus.spk_valid    = spk_valid_int;
    assign bus.spk_addr     = spk_valid_int ? mem[rd_ptr] : '0;

    // A fire sample must never arrive while the FIFO is full.
    a_no_overflow: assert property (@(posedge clk_soma) disable iff (!rst_n)
        !(vld_p1 && !clear_p1 && bus.soma_fire && count == DEPTH_C));

endmodule
